// File: rtl/pcm_rx_pkg.sv
// pcm_rx_pkg: shared state encoding, counter widths and sync-width helpers for the PCM receiver.
package pcm_rx_pkg;
    localparam logic [2:0] ST_HUNT  = 3'b001;
    localparam logic [2:0] ST_DATA  = 3'b010;
    localparam logic [2:0] ST_CHECK = 3'b100;
    localparam int FRAME_CNT_W = 32;
    localparam int ERR_CNT_W   = 16;

    // number_i counts down: 0 selects a 4-byte sync, 3 selects a 1-byte sync
    function automatic logic [5:0] sync_width(input logic [1:0] number);
        return {3'd4 - {1'b0, number}, 3'b000};
    endfunction

    function automatic logic [31:0] sync_mask(input logic [5:0] w);
        return 32'hFFFF_FFFF >> (6'd32 - w);
    endfunction
endpackage

// File: rtl/pcm_edge_sync.sv
// pcm_edge_sync: synchronizes PCM clock/data into clk_i and strobes one sampled bit per selected PCM clock edge.
module pcm_edge_sync (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic pcm_clk_i,
    input  logic pcm_data_i,
    input  logic edge_i,
    output logic strobe_o,
    output logic bit_o
);
    logic [1:0] clk_sync;
    logic [1:0] dat_sync;
    logic       clk_prev;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            clk_sync <= '0;
            dat_sync <= '0;
            clk_prev <= 1'b0;
            strobe_o <= 1'b0;
            bit_o    <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[0], pcm_clk_i};
            dat_sync <= {dat_sync[0], pcm_data_i};
            clk_prev <= clk_sync[1];
            strobe_o <= edge_i ? (clk_sync[1] & ~clk_prev) : (~clk_sync[1] & clk_prev);
            bit_o    <= dat_sync[1];
        end
    end
endmodule

// File: rtl/pcm_receiver.sv
// pcm_receiver: PCM sync hunt, flywheel frame lock and byte delivery.
// Define PCM_RX_PATTERN_CHECK_EN to build the incrementing test-pattern checker.
module pcm_receiver
    import pcm_rx_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        enable_i,
    input  logic        pcm_clk_i,
    input  logic        pcm_data_i,
    input  logic        edge_i,
    input  logic [31:0] code_i,
    input  logic [1:0]  number_i,
    input  logic [15:0] frame_len_i,
    input  logic [3:0]  miss_limit_i,
    output logic [7:0]  byte_o,
    output logic        byte_valid_o,
    output logic        frame_start_o,
    output logic        frame_end_o,
    output logic        lock_o,
    output logic [31:0] frame_cnt_o,
    output logic [15:0] sync_err_cnt_o,
    output logic [15:0] pat_err_cnt_o
);
    logic        strobe;
    logic        sbit;
    logic [2:0]  state;
    logic [31:0] shreg;
    logic [2:0]  bit_cnt;
    logic [15:0] byte_cnt;
    logic [5:0]  chk_cnt;
    logic [4:0]  miss_cnt;
    logic [5:0]  w;
    logic [31:0] shnext;
    logic [15:0] last_byte;
    logic        sync_hit;

    pcm_edge_sync u_edge_sync (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .pcm_clk_i  (pcm_clk_i),
        .pcm_data_i (pcm_data_i),
        .edge_i     (edge_i),
        .strobe_o   (strobe),
        .bit_o      (sbit)
    );

    always_comb begin
        w         = sync_width(number_i);
        shnext    = {shreg[30:0], sbit};
        sync_hit  = ((shnext ^ code_i) & sync_mask(w)) == 32'h0;
        last_byte = (frame_len_i == 16'd0) ? 16'd0 : frame_len_i - 16'd1;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state          <= ST_HUNT;
            shreg          <= '0;
            bit_cnt        <= '0;
            byte_cnt       <= '0;
            chk_cnt        <= '0;
            miss_cnt       <= '0;
            byte_o         <= '0;
            byte_valid_o   <= 1'b0;
            frame_start_o  <= 1'b0;
            frame_end_o    <= 1'b0;
            lock_o         <= 1'b0;
            frame_cnt_o    <= '0;
            sync_err_cnt_o <= '0;
        end else begin
            byte_valid_o  <= 1'b0;
            frame_start_o <= 1'b0;
            frame_end_o   <= 1'b0;
            if (strobe) shreg <= shnext;
            if (!enable_i) begin
                state    <= ST_HUNT;
                bit_cnt  <= '0;
                byte_cnt <= '0;
                chk_cnt  <= '0;
                miss_cnt <= '0;
                lock_o   <= 1'b0;
            end else if (strobe) begin
                if (state == ST_HUNT) begin
                    if (sync_hit) begin
                        state    <= ST_DATA;
                        bit_cnt  <= '0;
                        byte_cnt <= '0;
                    end
                end else if (state == ST_DATA) begin
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        byte_o        <= shnext[7:0];
                        byte_valid_o  <= 1'b1;
                        frame_start_o <= byte_cnt == 16'd0;
                        frame_end_o   <= byte_cnt == last_byte;
                        byte_cnt      <= byte_cnt + 16'd1;
                        if (byte_cnt == last_byte) begin
                            frame_cnt_o <= frame_cnt_o + 32'd1;
                            byte_cnt    <= '0;
                            chk_cnt     <= '0;
                            state       <= ST_CHECK;
                        end
                    end
                end else begin
                    chk_cnt <= chk_cnt + 6'd1;
                    // compare only once the whole sync word has been shifted in
                    if (chk_cnt == w - 6'd1) begin
                        state   <= ST_DATA;
                        bit_cnt <= '0;
                        if (sync_hit) begin
                            lock_o   <= 1'b1;
                            miss_cnt <= '0;
                        end else begin
                            if (sync_err_cnt_o != {ERR_CNT_W{1'b1}}) sync_err_cnt_o <= sync_err_cnt_o + 16'd1;
                            miss_cnt <= miss_cnt + 5'd1;
                            if (miss_cnt + 5'd1 > {1'b0, miss_limit_i}) begin
                                state  <= ST_HUNT;
                                lock_o <= 1'b0;
                            end
                        end
                    end
                end
            end
        end
    end

`ifdef PCM_RX_PATTERN_CHECK_EN
    logic [7:0] pat_prev;
    logic       pat_seeded;

    // the first byte after a fresh sync acquisition only seeds the expectation
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pat_prev      <= '0;
            pat_seeded    <= 1'b0;
            pat_err_cnt_o <= '0;
        end else if (state == ST_HUNT) begin
            pat_seeded <= 1'b0;
        end else if (byte_valid_o) begin
            pat_prev   <= byte_o;
            pat_seeded <= 1'b1;
            if (pat_seeded && byte_o != pat_prev + 8'd1 && pat_err_cnt_o != {ERR_CNT_W{1'b1}})
                pat_err_cnt_o <= pat_err_cnt_o + 16'd1;
        end
    end
`else
    assign pat_err_cnt_o = '0;
`endif
endmodule

// File: tb/tb_pcm_receiver.sv
// tb_pcm_receiver: drives PCM bit streams and checks the receiver against a bit-stream walking reference model.
module tb_pcm_receiver;
    logic        clk = 0, rst_n = 0, enable = 0, pcm_clk = 0, pcm_data = 0, edge_sel = 0;
    logic [31:0] code = 0;
    logic [1:0]  number = 0;
    logic [15:0] frame_len = 1;
    logic [3:0]  miss_limit = 0;
    logic [7:0]  byte_out;
    logic        byte_valid, frame_start, frame_end, lock;
    logic [31:0] frame_cnt;
    logic [15:0] sync_err_cnt, pat_err_cnt;

    localparam int H = 37;
`ifdef PCM_RX_PATTERN_CHECK_EN
    localparam bit PAT_EN = 1'b1;
`else
    localparam bit PAT_EN = 1'b0;
`endif

    int checks = 0, errors = 0;
    bit tx_bits[$];
    int tx_sent;
    logic [9:0] got_q[$], exp_q[$];
    int exp_frames, exp_serr, exp_pat;
    bit exp_lock;

    pcm_receiver dut (
        .clk_i(clk), .rst_n_i(rst_n), .enable_i(enable), .pcm_clk_i(pcm_clk), .pcm_data_i(pcm_data),
        .edge_i(edge_sel), .code_i(code), .number_i(number), .frame_len_i(frame_len), .miss_limit_i(miss_limit),
        .byte_o(byte_out), .byte_valid_o(byte_valid), .frame_start_o(frame_start), .frame_end_o(frame_end),
        .lock_o(lock), .frame_cnt_o(frame_cnt), .sync_err_cnt_o(sync_err_cnt), .pat_err_cnt_o(pat_err_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (byte_valid) got_q.push_back({frame_start, frame_end, byte_out});

    task automatic push_bits(input logic [31:0] v, input int n);
        for (int k = n - 1; k >= 0; k--) tx_bits.push_back(v[k]);
    endtask

    task automatic push_rand(input int n);
        for (int k = 0; k < n; k++) tx_bits.push_back(1'($urandom_range(0, 1)));
    endtask

    // Walks the whole transmitted bit history: hunt, frame of bytes, sync check, repeat.
    task automatic run_model(input int flen_raw, input int w, input logic [31:0] c, input int limit);
        logic [31:0] acc, mask;
        logic [7:0] b, prev;
        int i, n, miss, flen;
        bit hunting, seeded;
        mask = (w == 32) ? 32'hFFFF_FFFF : (32'h1 << w) - 32'h1;
        flen = (flen_raw == 0) ? 1 : flen_raw;
        exp_q.delete();
        exp_lock = 0; exp_serr = 0; exp_frames = 0; exp_pat = 0;
        acc = 0; b = 0; prev = 0; i = 0; n = tx_bits.size(); miss = 0; hunting = 1; seeded = 0;
        while (i < n) begin
            if (hunting) begin
                acc = {acc[30:0], tx_bits[i]}; i++;
                if (((acc ^ c) & mask) == 0) begin hunting = 0; seeded = 0; end
            end else begin
                for (int k = 0; k < flen; k++) begin
                    if (i + 8 > n) return;
                    for (int j = 0; j < 8; j++) begin
                        acc = {acc[30:0], tx_bits[i]}; b = {b[6:0], tx_bits[i]}; i++;
                    end
                    exp_q.push_back({k == 0, k == flen - 1, b});
                    if (seeded && b != 8'(prev + 8'd1)) exp_pat++;
                    prev = b; seeded = 1;
                    if (k == flen - 1) exp_frames++;
                end
                if (i + w > n) return;
                for (int j = 0; j < w; j++) begin acc = {acc[30:0], tx_bits[i]}; i++; end
                if (((acc ^ c) & mask) == 0) begin exp_lock = 1; miss = 0; end
                else begin
                    exp_serr++; miss++;
                    if (miss > limit) begin hunting = 1; exp_lock = 0; end
                end
            end
        end
    endtask

    task automatic send_stream(input bit scheme);
        while (tx_sent < tx_bits.size()) begin
            if (!scheme) begin pcm_clk = 1; pcm_data = tx_bits[tx_sent]; #H; pcm_clk = 0; #H; end
            else begin pcm_clk = 0; pcm_data = tx_bits[tx_sent]; #H; pcm_clk = 1; #H; end
            tx_sent++;
        end
        #H pcm_clk = 0;
        repeat (12) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic setup(input bit e, input logic [1:0] n, input logic [31:0] c, input logic [15:0] fl, input logic [3:0] ml);
        enable = 0; edge_sel = e; number = n; code = c; frame_len = fl; miss_limit = ml;
        pcm_clk = 0; pcm_data = 0;
        #3 rst_n = 0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1;
        tx_bits.delete(); tx_sent = 0; got_q.delete();
        repeat (2) @(posedge clk);
        enable = 1;
        repeat (2) @(posedge clk);
    endtask

    function automatic int first_diff();
        int m;
        m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int k = 0; k < m; k++) if (got_q[k] !== exp_q[k]) return k;
        return (got_q.size() == exp_q.size()) ? -1 : m;
    endfunction

    task automatic test_reset();
        setup(0, 0, 32'h1ACFFC1D, 4, 0);
        checks++; if (byte_out !== 8'h0) begin errors++; $display("FAIL reset byte_o: got %h want 00", byte_out); end
        checks++; if ({byte_valid, frame_start, frame_end} !== 3'b0) begin errors++; $display("FAIL reset strobes: got %b want 000", {byte_valid, frame_start, frame_end}); end
        checks++; if (lock !== 1'b0) begin errors++; $display("FAIL reset lock: got %b want 0", lock); end
        checks++; if (frame_cnt !== 32'h0) begin errors++; $display("FAIL reset frame_cnt: got %h want 0", frame_cnt); end
        checks++; if (sync_err_cnt !== 16'h0) begin errors++; $display("FAIL reset sync_err: got %h want 0", sync_err_cnt); end
        checks++; if (pat_err_cnt !== 16'h0) begin errors++; $display("FAIL reset pat_err: got %h want 0", pat_err_cnt); end
    endtask

    task automatic test_sync4();
        int d;
        setup(0, 0, 32'h1ACFFC1D, 4, 2);
        push_rand(20);
        repeat (3) begin
            push_bits(code, 32);
            for (int b = 0; b < 4; b++) push_bits(32'(b), 8);
        end
        push_bits(code, 32);
        run_model(4, 32, code, 2);
        send_stream(0);
        d = first_diff();
        checks++; if (d >= 0) begin errors++; $display("FAIL sync4 bytes[%0d]: got %h want %h (n %0d/%0d)", d, got_q[d], exp_q[d], got_q.size(), exp_q.size()); end
        checks++; if (lock !== exp_lock) begin errors++; $display("FAIL sync4 lock: got %b want %b", lock, exp_lock); end
        checks++; if (frame_cnt !== 32'(exp_frames)) begin errors++; $display("FAIL sync4 frame_cnt: got %0d want %0d", frame_cnt, exp_frames); end
        checks++; if (sync_err_cnt !== 16'(exp_serr)) begin errors++; $display("FAIL sync4 sync_err: got %0d want %0d", sync_err_cnt, exp_serr); end
        enable = 0;
        repeat (3) @(negedge clk);
        checks++; if (lock !== 1'b0) begin errors++; $display("FAIL disable lock: got %b want 0", lock); end
        checks++; if (frame_cnt !== 32'(exp_frames)) begin errors++; $display("FAIL disable frame_cnt kept: got %0d want %0d", frame_cnt, exp_frames); end
    endtask

    task automatic test_sync1_len1();
        int d;
        setup(0, 3, 32'h000000EB, 1, 3);
        push_rand(12);
        repeat (6) begin push_bits(code, 8); push_bits($urandom, 8); end
        push_bits(code, 8);
        run_model(1, 8, code, 3);
        send_stream(0);
        d = first_diff();
        checks++; if (d >= 0) begin errors++; $display("FAIL len1 bytes[%0d]: got %h want %h (n %0d/%0d)", d, got_q[d], exp_q[d], got_q.size(), exp_q.size()); end
        checks++; if (frame_cnt !== 32'(exp_frames)) begin errors++; $display("FAIL len1 frame_cnt: got %0d want %0d", frame_cnt, exp_frames); end
        checks++; if (lock !== exp_lock) begin errors++; $display("FAIL len1 lock: got %b want %b", lock, exp_lock); end
    endtask

    task automatic test_len0();
        int d;
        setup(0, 2, 32'h00005A3C, 0, 0);
        push_bits(0, 10);
        repeat (4) begin push_bits(code, 16); push_bits($urandom, 8); end
        push_bits(code, 16);
        run_model(0, 16, code, 0);
        send_stream(0);
        d = first_diff();
        checks++; if (d >= 0) begin errors++; $display("FAIL len0 bytes[%0d]: got %h want %h (n %0d/%0d)", d, got_q[d], exp_q[d], got_q.size(), exp_q.size()); end
        checks++; if (frame_cnt !== 32'(exp_frames)) begin errors++; $display("FAIL len0 frame_cnt: got %0d want %0d", frame_cnt, exp_frames); end
    endtask

    task automatic test_flywheel();
        int d;
        logic [31:0] bad;
        setup(0, 0, 32'h1ACFFC1D, 2, 1);
        bad = code ^ (32'h1 << $urandom_range(0, 31));
        push_bits(0, 16);
        push_bits(code, 32); push_rand(16);
        push_bits(code, 32); push_rand(16);
        push_bits(bad, 32);  push_rand(16);
        push_bits(code, 32); push_rand(16);
        run_model(2, 32, code, 1);
        send_stream(0);
        checks++; if (lock !== exp_lock) begin errors++; $display("FAIL flywheel single-miss lock: got %b want %b", lock, exp_lock); end
        checks++; if (sync_err_cnt !== 16'(exp_serr)) begin errors++; $display("FAIL flywheel single-miss sync_err: got %0d want %0d", sync_err_cnt, exp_serr); end
        push_bits(bad, 32); push_rand(16);
        push_bits(~code, 32); push_rand(16);
        push_rand(16);
        run_model(2, 32, code, 1);
        send_stream(0);
        d = first_diff();
        checks++; if (d >= 0) begin errors++; $display("FAIL flywheel bytes[%0d]: got %h want %h (n %0d/%0d)", d, got_q[d], exp_q[d], got_q.size(), exp_q.size()); end
        checks++; if (lock !== exp_lock) begin errors++; $display("FAIL flywheel drop lock: got %b want %b", lock, exp_lock); end
        checks++; if (sync_err_cnt !== 16'(exp_serr)) begin errors++; $display("FAIL flywheel sync_err: got %0d want %0d", sync_err_cnt, exp_serr); end
    endtask

    task automatic test_edge_rise();
        int d;
        setup(1, 0, 32'h1ACFFC1D, 3, 0);
        push_rand(9);
        repeat (3) begin push_bits(code, 32); push_bits($urandom, 24); end
        push_bits(code, 32);
        run_model(3, 32, code, 0);
        send_stream(1);
        d = first_diff();
        checks++; if (d >= 0) begin errors++; $display("FAIL rise bytes[%0d]: got %h want %h (n %0d/%0d)", d, got_q[d], exp_q[d], got_q.size(), exp_q.size()); end
        checks++; if (lock !== exp_lock) begin errors++; $display("FAIL rise lock: got %b want %b", lock, exp_lock); end
    endtask

    task automatic test_reset_mid();
        int d;
        setup(0, 2, 32'h0000B562, 2, 0);
        push_bits(0, 8);
        push_bits(code, 16); push_rand(16); push_bits(code, 16); push_rand(3);
        run_model(2, 16, code, 0);
        send_stream(0);
        checks++; if (lock !== exp_lock) begin errors++; $display("FAIL midrst pre lock: got %b want %b", lock, exp_lock); end
        #3 rst_n = 0;
        #1;
        checks++; if ({lock, byte_valid, byte_out, frame_cnt} !== 42'h0) begin errors++; $display("FAIL midrst outputs: lock %b valid %b byte %h frames %0d want all 0", lock, byte_valid, byte_out, frame_cnt); end
        repeat (3) @(posedge clk);
        #2 rst_n = 1;
        d = first_diff();
        checks++; if (d >= 0) begin errors++; $display("FAIL midrst partial bytes[%0d]: got %h want %h (n %0d/%0d)", d, got_q[d], exp_q[d], got_q.size(), exp_q.size()); end
        tx_bits.delete(); tx_sent = 0; got_q.delete();
        push_bits(0, 5);
        push_bits(code, 16); push_rand(16); push_bits(code, 16); push_rand(16); push_bits(code, 16);
        run_model(2, 16, code, 0);
        send_stream(0);
        d = first_diff();
        checks++; if (d >= 0) begin errors++; $display("FAIL midrst reacquire bytes[%0d]: got %h want %h (n %0d/%0d)", d, got_q[d], exp_q[d], got_q.size(), exp_q.size()); end
        checks++; if (lock !== exp_lock) begin errors++; $display("FAIL midrst reacquire lock: got %b want %b", lock, exp_lock); end
    endtask

    task automatic test_pattern();
        int d;
        logic [7:0] v;
        setup(0, 1, 32'h00F3A51C, 8, 0);
        push_bits(0, 16);
        for (int f = 0; f < 3; f++) begin
            push_bits(code, 24);
            for (int k = 0; k < 8; k++) begin
                v = 8'(f * 8 + k);
                push_bits((v == 8'h12) ? 32'h55 : 32'(v), 8);
            end
        end
        push_bits(code, 24);
        run_model(8, 24, code, 0);
        send_stream(0);
        d = first_diff();
        checks++; if (d >= 0) begin errors++; $display("FAIL pattern bytes[%0d]: got %h want %h (n %0d/%0d)", d, got_q[d], exp_q[d], got_q.size(), exp_q.size()); end
        checks++; if (pat_err_cnt !== (PAT_EN ? 16'(exp_pat) : 16'h0)) begin errors++; $display("FAIL pattern model pat_err: got %0d want %0d", pat_err_cnt, PAT_EN ? exp_pat : 0); end
        checks++; if (pat_err_cnt !== (PAT_EN ? 16'd2 : 16'd0)) begin errors++; $display("FAIL pattern pat_err: got %0d want %0d", pat_err_cnt, PAT_EN ? 2 : 0); end
        checks++; if (frame_cnt !== 32'd3) begin errors++; $display("FAIL pattern frame_cnt: got %0d want 3", frame_cnt); end
    endtask

    initial begin
        test_reset();
        test_sync4();
        test_sync1_len1();
        test_len0();
        test_flywheel();
        test_edge_rise();
        test_reset_mid();
        test_pattern();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pcm_receiver.md
# pcm_receiver

Serial PCM receiver: the receive end of the team's PCM link (NRZ data plus bit clock, 1–4 byte sync word MSB-first, then fixed-length byte frames). It oversamples the incoming clock/data on the system clock, hunts for the sync word, tracks frame sync with a miss-tolerant flywheel, and delivers bytes on a one-cycle strobe interface. It sits between the board-level PCM input pins and the capture/FIFO logic.

## Interface
- No parameters; all configuration is by run-time ports.
- clk_i  in  1  main clock
- rst_n_i  in  1  reset, asynchronous, active-low
- enable_i  in  1  receiver enable; low forces HUNT and clears lock
- pcm_clk_i  in  1  PCM bit clock, asynchronous to clk_i
- pcm_data_i  in  1  PCM serial data, asynchronous to clk_i
- edge_i  in  1  0: sample on pcm_clk_i falling edge; 1: sample on rising edge
- code_i  in  32  sync word, right-justified (1 byte = code_i[7:0])
- number_i  in  2  sync length: 0 = 4 bytes, 1 = 3, 2 = 2, 3 = 1
- frame_len_i  in  16  data bytes per frame; 0 treated as 1
- miss_limit_i  in  4  consecutive sync misses tolerated before dropping lock
- byte_o  out  8  received byte
- byte_valid_o  out  1  one-cycle strobe, byte_o valid
- frame_start_o  out  1  with byte_valid_o on first byte of frame
- frame_end_o  out  1  with byte_valid_o on last byte of frame
- lock_o  out  1  frame sync confirmed
- frame_cnt_o  out  32  frames completed (wraps)
- sync_err_cnt_o  out  16  sync mismatches in CHECK (saturating)
- pat_err_cnt_o  out  16  test-pattern errors (saturating; see Configuration)

## Operation
- pcm_clk_i and pcm_data_i each pass a 2-FF synchronizer; a registered previous-clock copy gives the selected edge; sample strobe = selected edge detected; sampled bit = synchronized data at that strobe.
- Sync width W = 8 × (4 − number_i) bits. Compare value = code_i[W-1:0]; a 32-bit shift register collects samples MSB-first.
- States:
  - HUNT: shift each sample; when low W bits equal the compare value → DATA, byte/bit counters cleared. lock_o = 0.
  - DATA: count 8 bits per byte; on 8th bit, emit byte; after byte frame_len_i → CHECK.
  - CHECK: collect exactly W bits, then compare. Match → lock_o = 1, miss counter cleared, → DATA. Mismatch → sync_err_cnt_o++, miss counter++; if miss counter > miss_limit_i → HUNT (lock_o = 0), else → DATA (flywheel, lock_o unchanged).
- enable_i low: state → HUNT, counters in FSM cleared, lock_o = 0; status counters retain value.
- frame_cnt_o increments on each frame_end_o.
- number_i, code_i, frame_len_i sampled live; change only while enable_i low.

## Timing
- Reset: all outputs 0; state HUNT; shift register 0.
- Sample strobe occurs 3 clk_i cycles after the pcm_clk_i edge at the pin.
- byte_o/byte_valid_o/frame_* registered: asserted the cycle after the strobe of the byte's 8th bit, for exactly one cycle; byte_o holds until next strobe.
- HUNT → DATA transition on the cycle after the matching strobe; the very next sample is data bit 7.
- pcm_clk_i high and low phases must each be ≥ 3 clk_i cycles; shorter is unsupported.
- frame_len_i = 1: frame_start_o and frame_end_o in the same cycle.
- Counters: sync_err_cnt_o and pat_err_cnt_o stick at 0xFFFF; frame_cnt_o wraps 0xFFFF_FFFF → 0.
- Async reset mid-frame: immediate return to reset values; no partial byte emitted.

## Configuration
- PCM_RX_PATTERN_CHECK_EN defined: on-line checker for the incrementing test pattern (0x00..0xFF, continuous across frames). First byte after leaving HUNT seeds the expectation; each following byte must equal previous + 1 mod 256; mismatch → pat_err_cnt_o++ and reseed with received byte.
- Undefined: checker logic absent, pat_err_cnt_o tied to 0 (port retained).

## Structure
- pcm_rx_pkg: state encoding (one-hot HUNT/DATA/CHECK), sync-width decode function number_i → W, counter width constants.
- Sub-module pcm_edge_sync: 2-FF synchronizers plus edge select, outputs sample strobe and sampled bit.

## Test plan
- number_i=0, code_i=0x1ACFFC1D, frame_len_i=4, edge_i=0, bytes 00..03 → byte_valid_o ×4 with 00,01,02,03; frame_start_o on 00, frame_end_o on 03; lock_o rises after second sync.
- number_i=3, code_i=0xEB, frame_len_i=1 → each byte has frame_start_o and frame_end_o together; frame_cnt_o increments per frame.
- Corrupt one sync, miss_limit_i=1 → sync_err_cnt_o=1, lock_o stays 1, data continues; two consecutive corrupt → third miss drops lock_o, state HUNT.
- edge_i=1 with transmitter changing data on falling edge → identical bytes received; swap edge_i mismatch → no lock.
- Assert rst_n_i mid-byte, then release → all outputs 0, reacquire on next sync.
- With PCM_RX_PATTERN_CHECK_EN, inject byte 0x55 in place of 0x12 → pat_err_cnt_o = 2 (0x55 and following 0x13); without macro → 0.
